// File: rtl/instr_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : instr_fetch_stage                                        |
// | Description : PC, host-loadable instruction memory and IF/ID register  |
// |               with stall, jump redirect and optional end-of-memory     |
// |               halt (IFETCH_HALT_EN).                                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module instr_fetch_stage #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               jump_en,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               imem_we,
    input  logic [PC_W-1:0]    imem_waddr,
    input  logic [INSTR_W-1:0] imem_wdata,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc,
    output logic               if_id_valid,
    output logic               halted
);

    localparam int                 c_DEPTH  = 1 << PC_W;
    localparam logic [PC_W-1:0]    c_PC_MAX = {PC_W{1'b1}};
    localparam logic [PC_W-1:0]    c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [INSTR_W-1:0] c_BUBBLE = '0;

    logic [INSTR_W-1:0] r_mem [0:c_DEPTH-1];
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_if_id_instr;
    logic [PC_W-1:0]    r_if_id_pc;
    logic               r_if_id_valid;
    logic [INSTR_W-1:0] w_fetch_word;
    logic               w_halted;
    logic               w_stop_at_end;

    // Host load port; contents survive reset and ignore pipeline control.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            r_mem[imem_waddr] <= imem_wdata;
        end
    end

    // Read uses the pre-edge array, so a same-edge write is seen next fetch.
    assign w_fetch_word = r_mem[r_pc];

`ifdef IFETCH_HALT_EN
    logic r_halted;

    assign w_stop_at_end = (r_pc == c_PC_MAX);
    assign w_halted      = r_halted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (jump_en) begin
            r_halted <= 1'b0;
        end else if (!stall && !r_halted && w_stop_at_end) begin
            r_halted <= 1'b1;
        end
    end
`else
    assign w_stop_at_end = 1'b0;
    assign w_halted      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_if_id_instr <= c_BUBBLE;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
        end else if (jump_en) begin
            r_pc          <= jump_target;
            r_if_id_instr <= c_BUBBLE;
            r_if_id_valid <= 1'b0;
        end else if (stall) begin
            r_pc          <= r_pc;
        end else if (w_halted) begin
            r_if_id_instr <= c_BUBBLE;
            r_if_id_valid <= 1'b0;
        end else begin
            r_if_id_instr <= w_fetch_word;
            r_if_id_pc    <= r_pc;
            r_if_id_valid <= 1'b1;
            // With halt enabled the last word is delivered but PC parks there.
            r_pc          <= w_stop_at_end ? r_pc : r_pc + c_PC_ONE;
        end
    end

    assign pc          = r_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;
    assign halted      = w_halted;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_stage                                     |
// | Description : Directed self-checking bench for instr_fetch_stage.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_instr_fetch_stage;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       jump_en;
    logic [3:0] jump_target;
    logic       imem_we;
    logic [3:0] imem_waddr;
    logic [7:0] imem_wdata;
    logic [3:0] pc;
    logic [7:0] if_id_instr;
    logic [3:0] if_id_pc;
    logic       if_id_valid;
    logic       halted;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] prog [16];

    instr_fetch_stage #(.PC_W(4), .INSTR_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_pc, input logic [7:0] e_instr,
                             input logic [3:0] e_ifpc, input logic e_valid, input logic e_halted);
        check({tag, ".pc"},     {4'h0, pc},          {4'h0, e_pc});
        check({tag, ".instr"},  if_id_instr,         e_instr);
        check({tag, ".if_pc"},  {4'h0, if_id_pc},    {4'h0, e_ifpc});
        check({tag, ".valid"},  {7'h0, if_id_valid}, {7'h0, e_valid});
        check({tag, ".halted"}, {7'h0, halted},      {7'h0, e_halted});
    endtask

    initial begin
        prog[0] = 8'h41; prog[1] = 8'h05; prog[2] = 8'hC3; prog[3] = 8'h46;
        for (int i = 4; i < 16; i++) prog[i] = 8'h10 + 8'(i);
        prog[9] = 8'h7F;

        reset = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_target = 4'h0;
        imem_we = 1'b0; imem_waddr = 4'h0; imem_wdata = 8'h00;

        // Load the program image while held in reset.
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            imem_we = 1'b1; imem_waddr = 4'(i); imem_wdata = prog[i];
            step();
        end
        imem_we = 1'b0;
        step();
        check_all("reset", 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);

        // Straight-line fetch
        reset = 1'b0;
        step(); check_all("fetch0", 4'h1, 8'h41, 4'h0, 1'b1, 1'b0);
        step(); check_all("fetch1", 4'h2, 8'h05, 4'h1, 1'b1, 1'b0);

        // Stall for two cycles
        stall = 1'b1;
        step(); check_all("stall_a", 4'h2, 8'h05, 4'h1, 1'b1, 1'b0);
        step(); check_all("stall_b", 4'h2, 8'h05, 4'h1, 1'b1, 1'b0);
        stall = 1'b0;
        step(); check_all("fetch2", 4'h3, 8'hC3, 4'h2, 1'b1, 1'b0);
        step(); check_all("fetch3", 4'h4, 8'h46, 4'h3, 1'b1, 1'b0);

        // Jump overriding stall
        jump_en = 1'b1; jump_target = 4'h9; stall = 1'b1;
        step(); check_all("jump_bub", 4'h9, 8'h00, 4'h3, 1'b0, 1'b0);
        jump_en = 1'b0; stall = 1'b0;
        step(); check_all("jump_tgt", 4'hA, 8'h7F, 4'h9, 1'b1, 1'b0);

        // Run to the end of memory
        for (int a = 10; a < 15; a++) begin
            step();
            check_all("run", 4'(a + 1), prog[a], 4'(a), 1'b1, 1'b0);
        end
`ifdef IFETCH_HALT_EN
        step(); check_all("end15",  4'hF, 8'h1F, 4'hF, 1'b1, 1'b1);
        step(); check_all("halt_b", 4'hF, 8'h00, 4'hF, 1'b0, 1'b1);
        jump_en = 1'b1; jump_target = 4'h0;
        step(); check_all("unhalt", 4'h0, 8'h00, 4'hF, 1'b0, 1'b0);
`else
        step(); check_all("end15",  4'h0, 8'h1F, 4'hF, 1'b1, 1'b0);
        step(); check_all("wrap0",  4'h1, 8'h41, 4'h0, 1'b1, 1'b0);
        jump_en = 1'b1; jump_target = 4'h0;
        step(); check_all("rejump", 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
`endif
        jump_en = 1'b0;
        step(); check_all("refetch0", 4'h1, 8'h41, 4'h0, 1'b1, 1'b0);
        step(); check_all("refetch1", 4'h2, 8'h05, 4'h1, 1'b1, 1'b0);

        // Write collision at the address being fetched
        imem_we = 1'b1; imem_waddr = 4'h2; imem_wdata = 8'hAA;
        step(); check_all("coll_old", 4'h3, 8'hC3, 4'h2, 1'b1, 1'b0);
        imem_we = 1'b0;
        jump_en = 1'b1; jump_target = 4'h2;
        step(); check_all("coll_jmp", 4'h2, 8'h00, 4'h2, 1'b0, 1'b0);
        jump_en = 1'b0;
        step(); check_all("coll_new", 4'h3, 8'hAA, 4'h2, 1'b1, 1'b0);

        // Reset wins over jump; memory survives
        reset = 1'b1; jump_en = 1'b1; jump_target = 4'h7;
        step(); check_all("rst_mid", 4'h0, 8'h00, 4'h0, 1'b0, 1'b0);
        reset = 1'b0; jump_en = 1'b0;
        step(); check_all("rst_refetch", 4'h1, 8'h41, 4'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
